// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: Y86-64 pipeline stall/bubble control with RUN/MWAIT/HALT run state.
// Defining PIPE_PERF_CNT_EN adds cycle/stall/bubble performance counters.
module pipe_ctrl_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [3:0]       D_icode_i,
  input  logic [3:0]       d_srcA_i,
  input  logic [3:0]       d_srcB_i,
  input  logic [3:0]       E_icode_i,
  input  logic [3:0]       E_dstM_i,
  input  logic             e_Cnd_i,
  input  logic [3:0]       M_icode_i,
  input  logic             M_mem_req_i,
  input  logic             dmem_ack_i,
  input  logic [2:0]       m_stat_i,
  input  logic [2:0]       W_stat_i,
  output logic             F_stall_o,
  output logic             D_stall_o,
  output logic             D_bubble_o,
  output logic             E_stall_o,
  output logic             E_bubble_o,
  output logic             M_stall_o,
  output logic             M_bubble_o,
  output logic             W_stall_o,
  output logic             W_bubble_o,
  output logic             set_cc_o,
  output logic [1:0]       state_o,
`ifdef PIPE_PERF_CNT_EN
  output logic [CNT_W-1:0] cyc_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
`endif
  output logic             mem_err_o
);
  typedef enum logic [1:0] {RUN = 2'd0, MWAIT = 2'd1, HALT = 2'd2} state_t;
  localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);
  localparam logic [3:0] MRMOVQ = 4'h5, OPQ = 4'h6, JXX = 4'h7, IRET = 4'h9, POPQ = 4'hB, RNONE = 4'hF;
  localparam logic [2:0] SAOK = 3'd1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic loaduse, retp, misp, exc_m, exc_w, memwait, d_bub, hold;
  assign loaduse = (E_icode_i == MRMOVQ || E_icode_i == POPQ) && E_dstM_i != RNONE &&
                   (E_dstM_i == d_srcA_i || E_dstM_i == d_srcB_i);
  assign retp    = D_icode_i == IRET || E_icode_i == IRET || M_icode_i == IRET;
  assign misp    = E_icode_i == JXX && !e_Cnd_i;
  assign exc_m   = m_stat_i != SAOK;
  assign exc_w   = W_stat_i != SAOK;
  assign memwait = M_mem_req_i && !dmem_ack_i && !exc_w;
  assign d_bub   = misp || (!loaduse && retp);
  // an ack in MWAIT lets M advance this cycle, so that cycle is decoded as RUN
  assign hold    = (state_q == MWAIT && !dmem_ack_i) || (state_q == RUN && memwait);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    err_d = err_q;
    {F_stall_o, D_stall_o, D_bubble_o, E_stall_o, E_bubble_o} = '0;
    {M_stall_o, M_bubble_o, W_stall_o, W_bubble_o, set_cc_o} = '0;
    if (!rst_n_i) begin
      {D_bubble_o, E_bubble_o, M_bubble_o, W_bubble_o} = 4'hF;
    end else if (state_q == HALT) begin
      {F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o} = 5'h1F;
    end else if (hold) begin
      {F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_bubble_o} = 5'h1F;
      cnt_d = state_q == RUN ? '0 : (cnt_q == LAST ? cnt_q : cnt_q + 1'b1);
      state_d = state_q == MWAIT && cnt_q == LAST ? HALT : MWAIT;
      err_d = err_q || (state_q == MWAIT && cnt_q == LAST);
    end else begin
      F_stall_o = loaduse || retp;
      D_bubble_o = d_bub;
      D_stall_o = loaduse && !d_bub;
      E_bubble_o = misp || loaduse;
      M_bubble_o = exc_m || exc_w;
      W_stall_o = exc_w;
      set_cc_o = E_icode_i == OPQ && !exc_m && !exc_w;
      cnt_d = '0;
      state_d = exc_w ? HALT : RUN;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= RUN;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign state_o = state_q;
  assign mem_err_o = err_q;
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, stall_q, bub_q;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cyc_q <= '0;
      stall_q <= '0;
      bub_q <= '0;
    end else if (state_q != HALT) begin
      cyc_q <= cyc_q + 1'b1;
      stall_q <= stall_q + CNT_W'(F_stall_o);
      bub_q <= bub_q + CNT_W'(E_bubble_o);
    end
  end
  assign cyc_cnt_o = cyc_q;
  assign stall_cnt_o = stall_q;
  assign bubble_cnt_o = bub_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: scoreboard bench for pipe_ctrl_unit hazard, MWAIT and HALT control.
module tb_pipe_ctrl_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic e_Cnd, M_mem_req, dmem_ack;
  logic [2:0] m_stat, W_stat;
  logic F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble, W_stall, W_bubble, set_cc, mem_err;
  logic [1:0] state;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cyc_cnt, stall_cnt, bubble_cnt;
`endif
  int checks = 0, errors = 0;
  logic [12:0] sb[$];
  logic [12:0] got, e;

  pipe_ctrl_unit #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
    .E_icode_i(E_icode), .E_dstM_i(E_dstM), .e_Cnd_i(e_Cnd), .M_icode_i(M_icode),
    .M_mem_req_i(M_mem_req), .dmem_ack_i(dmem_ack), .m_stat_i(m_stat), .W_stat_i(W_stat),
    .F_stall_o(F_stall), .D_stall_o(D_stall), .D_bubble_o(D_bubble), .E_stall_o(E_stall),
    .E_bubble_o(E_bubble), .M_stall_o(M_stall), .M_bubble_o(M_bubble), .W_stall_o(W_stall),
    .W_bubble_o(W_bubble), .set_cc_o(set_cc), .state_o(state),
`ifdef PIPE_PERF_CNT_EN
    .cyc_cnt_o(cyc_cnt), .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt),
`endif
    .mem_err_o(mem_err));

  always #5 clk = ~clk;

  function automatic logic [12:0] pk(input logic f, ds, db, es, eb, ms, mb, ws, wb, cc,
                                     input logic [1:0] st, input logic er);
    return {f, ds, db, es, eb, ms, mb, ws, wb, cc, st, er};
  endfunction

  function automatic logic [12:0] obs();
    return {F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble, W_stall, W_bubble, set_cc, state, mem_err};
  endfunction

  task automatic idle();
    D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF; E_icode = 4'h1; E_dstM = 4'hF; e_Cnd = 1'b0;
    M_icode = 4'h1; M_mem_req = 1'b0; dmem_ack = 1'b0; m_stat = 3'd1; W_stat = 3'd1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    E_icode = 4'h6;
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(pk(0,0,1,0,1,0,1,0,1,0,2'd0,0));
      @(negedge clk); got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset[%0d]: got %b want %b", i, got, e); end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_loaduse();
    logic [3:0] ei [4] = '{4'h5, 4'hB, 4'h5, 4'h5};
    logic [3:0] dm [4] = '{4'h3, 4'h7, 4'hF, 4'h3};
    logic [3:0] sa [4] = '{4'h3, 4'h1, 4'hF, 4'h2};
    logic [3:0] sbb[4] = '{4'hF, 4'h7, 4'hF, 4'h4};
    logic       hz [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      idle();
      E_icode = ei[i]; E_dstM = dm[i]; d_srcA = sa[i]; d_srcB = sbb[i];
      sb.push_back(pk(hz[i],hz[i],0,0,hz[i],0,0,0,0,0,2'd0,0));
      @(negedge clk); got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL loaduse[%0d]: got %b want %b", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_ret();
    for (int i = 0; i < 7; i++) begin
      idle();
      case (i)
        0: begin E_icode = 4'h7; e_Cnd = 1'b0; sb.push_back(pk(0,0,1,0,1,0,0,0,0,0,2'd0,0)); end
        1: begin E_icode = 4'h7; e_Cnd = 1'b1; sb.push_back(pk(0,0,0,0,0,0,0,0,0,0,2'd0,0)); end
        2: begin D_icode = 4'h9; sb.push_back(pk(1,0,1,0,0,0,0,0,0,0,2'd0,0)); end
        3: begin E_icode = 4'h9; sb.push_back(pk(1,0,1,0,0,0,0,0,0,0,2'd0,0)); end
        4: begin M_icode = 4'h9; sb.push_back(pk(1,0,1,0,0,0,0,0,0,0,2'd0,0)); end
        5: begin D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
                 sb.push_back(pk(1,1,0,0,1,0,0,0,0,0,2'd0,0)); end
        default: begin D_icode = 4'h9; E_icode = 4'h7; sb.push_back(pk(1,0,1,0,1,0,0,0,0,0,2'd0,0)); end
      endcase
      @(negedge clk); got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL branch_ret[%0d]: got %b want %b", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cc();
    for (int i = 0; i < 3; i++) begin
      idle();
      E_icode = 4'h6;
      m_stat = i == 1 ? 3'd3 : 3'd1;
      sb.push_back(i == 1 ? pk(0,0,0,0,0,0,1,0,0,0,2'd0,0) : pk(0,0,0,0,0,0,0,0,0,1,2'd0,0));
      @(negedge clk); got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL cc[%0d]: got %b want %b", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mwait();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      M_mem_req = i < 4 || i == 5;
      dmem_ack = i >= 3;
      case (i)
        0: sb.push_back(pk(1,1,0,1,0,1,0,0,1,0,2'd0,0));
        1, 2: sb.push_back(pk(1,1,0,1,0,1,0,0,1,0,2'd1,0));
        3: sb.push_back(pk(0,0,0,0,0,0,0,0,0,0,2'd1,0));
        default: sb.push_back(pk(0,0,0,0,0,0,0,0,0,0,2'd0,0));
      endcase
      @(negedge clk); got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL mwait[%0d]: got %b want %b", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ack_last();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      idle();
      M_mem_req = i <= 16;
      dmem_ack = i == 16;
      sb.push_back(i == 0  ? pk(1,1,0,1,0,1,0,0,1,0,2'd0,0) :
                   i < 16  ? pk(1,1,0,1,0,1,0,0,1,0,2'd1,0) :
                   i == 16 ? pk(0,0,0,0,0,0,0,0,0,0,2'd1,0) : pk(0,0,0,0,0,0,0,0,0,0,2'd0,0));
      @(negedge clk); got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL ack_last[%0d]: got %b want %b", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 23; i++) begin
      idle();
      M_mem_req = 1'b1;
      dmem_ack = i >= 17;
      rst_n = i < 20;
      sb.push_back(i == 0  ? pk(1,1,0,1,0,1,0,0,1,0,2'd0,0) :
                   i <= 16 ? pk(1,1,0,1,0,1,0,0,1,0,2'd1,0) :
                   i < 20  ? pk(1,1,0,1,0,1,0,1,0,0,2'd2,1) :
                   i == 20 ? pk(0,0,1,0,1,0,1,0,1,0,2'd2,1) : pk(0,0,1,0,1,0,1,0,1,0,2'd0,0));
      @(negedge clk); got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL timeout[%0d]: got %b want %b", i, got, e); end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mwait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle();
      M_mem_req = i < 3;
      rst_n = i != 2;
      sb.push_back(i == 0 ? pk(1,1,0,1,0,1,0,0,1,0,2'd0,0) :
                   i == 1 ? pk(1,1,0,1,0,1,0,0,1,0,2'd1,0) :
                   i == 2 ? pk(0,0,1,0,1,0,1,0,1,0,2'd1,0) : pk(0,0,0,0,0,0,0,0,0,0,2'd0,0));
      @(negedge clk); got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset_mwait[%0d]: got %b want %b", i, got, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_exc_w();
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] cyc0 = '0;
`endif
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle();
      E_icode = 4'h6;
      W_stat = i == 0 ? 3'd3 : 3'd1;
      M_mem_req = 1'b1;
      dmem_ack = i == 3;
      sb.push_back(i == 0 ? pk(0,0,0,0,0,0,1,1,0,0,2'd0,0) : pk(1,1,0,1,0,1,0,1,0,0,2'd2,0));
      @(negedge clk); got = obs(); e = sb.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL exc_w[%0d]: got %b want %b", i, got, e); end
`ifdef PIPE_PERF_CNT_EN
      if (i == 1) cyc0 = cyc_cnt;
      if (i == 3) begin
        checks++;
        if (cyc_cnt !== cyc0) begin errors++; $display("FAIL halt_cyc_cnt: got %0d want %0d", cyc_cnt, cyc0); end
      end
`endif
      @(posedge clk); #1;
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_loaduse();
    test_branch_ret();
    test_cc();
    test_mwait();
    test_ack_last();
    test_timeout();
    test_reset_mwait();
    test_exc_w();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
